eaglesong_digest_arbiter: RTL and testbench
===========================================

// Module: eaglesong_digest_arbiter
// PURPOSE
//  Shares one eaglesong_digest_top core among NUM_REQ requesters. Round-robin
//  grant, latches the winner's message, sequences the core's start/ready
//  protocol and returns the 256-bit digest to the granted requester.
//  Sits between the requester fabric and the single digest core instance.
// PARAMETERS
//  NUM_REQ      4    requester count, 2..8
//  START_CYCLES 2    cycles core_start_eval is held high per job, >=1
//  TIMEOUT      120  max WAIT cycles before job aborts with error
// PORTS
//  clk                    in   1          core clock, rising edge
//  rst_n                  in   1          async reset, active low
//  req_valid              in   NUM_REQ    requester i has a job
//  req_ready              out  NUM_REQ    job accept, one-hot pulse
//  req_data               in   NUM_REQ*256 message i = [i*256 +: 256], byte0 = LSB
//  req_len                in   NUM_REQ*7  length i in bytes = [i*7 +: 7]
//  resp_valid             out  NUM_REQ    result for requester i, one-hot
//  resp_ready             in   NUM_REQ    requester i takes result
//  resp_data              out  256        digest, byte-reversed as core emits
//  resp_err               out  1          1 = bad length or timeout, data = 0
//  core_input_val         out  256        to core input_val
//  core_input_length_bytes out 7          to core input_length_bytes
//  core_start_eval        out  1          to core start_eval
//  core_output_val        in   256        from core output_val
//  core_eval_output_ready in   1          from core eval_output_ready
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, rr_ptr=0, all outputs 0.
//  FSM: IDLE -> START -> WAIT -> RESP -> IDLE; IDLE -> RESP on bad length.
//  IDLE: if any req_valid, pick first set bit at or after rr_ptr (wrap mod
//    NUM_REQ); pulse req_ready[g] one cycle; latch data, len, g.
//    rr_ptr <= g+1 (wrap). Accepted data/len must not be re-read later.
//  Length check at accept: len==0 or len>32 -> resp_err=1, resp_data=0, go
//    to RESP next cycle; core not started.
//  START: core_start_eval=1 for exactly START_CYCLES cycles; core_input_val
//    and core_input_length_bytes driven from latch, stable START..WAIT.
//  WAIT: core_start_eval=0; cycle counter from 0. First cycle with
//    core_eval_output_ready==1 -> latch core_output_val, resp_err=0, RESP.
//    Ready is sampled only in WAIT (stale ready during START ignored).
//    Counter reaching TIMEOUT with no ready -> resp_err=1, resp_data=0, RESP.
//  RESP: resp_valid[g]=1, resp_data/resp_err stable, held until
//    resp_ready[g]=1; transfer on that edge, then IDLE. resp_ready of
//    other requesters ignored.
//  Accept-to-start latency 1 cycle; one job in flight; no req_ready
//    outside IDLE.
//  Requester whose req_valid drops after accept still gets its response.
//  Simultaneous req_valid: rr order strict; no requester starves beyond
//    NUM_REQ-1 jobs.
//  Async reset mid-job: immediate return to reset values; in-flight job lost;
//    core_start_eval low.
//  core_input_* outputs = 0 in IDLE.
// TESTING
//  1 Req0 "Hello, world!\n" (256'h0A21646C726F77202C6F6C6C6548, len 14) ->
//    resp_valid[0], resp_err=0, resp_data=256'hD6727D073CE7EC1ECA9F52DBD0E4954B3F4DCB6B0B43C25D6162D141247E8664.
//  2 All 4 req_valid at once from reset -> grants 0,1,2,3 in order; each
//    resp matches its own message; req_ready only in IDLE.
//  3 req_len=0 and req_len=33 -> resp_err=1, resp_data=0, core_start_eval
//    never asserts.
//  4 Core model never raises ready -> resp_err=1 after exactly 120 WAIT cycles.
//  5 Hold resp_ready low 10 cycles -> resp_valid/resp_data stable, no new
//    req_ready; then ack -> IDLE next cycle.
//  6 rst_n low during WAIT -> all outputs 0 same cycle; next job after
//    release completes with correct digest.

Source files
------------

// File: rtl/eaglesong_digest_arbiter.sv
// eaglesong_digest_arbiter
//
// Purpose:
//   Shares a single Eaglesong digest core among NUM_REQ requesters. A
//   round-robin arbiter picks one pending job and copies its message and
//   length into local registers. It then runs the core's start/ready
//   handshake and hands the 256-bit digest (or an error) back to the
//   requester that was granted. Only one job is in flight at a time.
//
// Parameters:
//   NUM_REQ       number of requesters (2..8)
//   START_CYCLES  cycles core_start_eval is held high per job (>= 1)
//   TIMEOUT       cycles to wait for the core before aborting with an error
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   req_valid / req_ready    per-requester job handshake; ready is a one-hot
//                            single-cycle accept pulse
//   req_data / req_len       message i = req_data[i*256 +: 256],
//                            length i = req_len[i*7 +: 7] bytes
//   resp_valid / resp_ready  per-requester result handshake, resp_valid one-hot
//   resp_data / resp_err     digest as emitted by the core; err => data is zero
//   core_*                   connection to the shared digest core

module eaglesong_digest_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 120
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*256-1:0] req_data,
    input  logic [NUM_REQ*7-1:0]   req_len,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [255:0]           resp_data,
    output logic                   resp_err,
    output logic [255:0]           core_input_val,
    output logic [6:0]             core_input_length_bytes,
    output logic                   core_start_eval,
    input  logic [255:0]           core_output_val,
    input  logic                   core_eval_output_ready
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (START_CYCLES > TIMEOUT) ? START_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q,  state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q,    gnt_d;
    logic [255:0]       data_q,   data_d;
    logic [6:0]         len_q,    len_d;
    logic [255:0]       result_q, result_d;
    logic               err_q,    err_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    int                 cand;
    logic [PTR_W-1:0]   cand_idx;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [255:0]       pick_data;
    logic [6:0]         pick_len;
    logic               pick_len_bad;

    // Round-robin search: walk the requesters starting at rr_ptr and wrap
    // around, taking the first one with a pending job.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign pick_data    = req_data[int'(pick_idx) * 256 +: 256];
    assign pick_len     = req_len[int'(pick_idx) * 7 +: 7];
    // The core only hashes 1..32 byte messages; anything else is refused at accept.
    assign pick_len_bad = (pick_len == 7'd0) || (pick_len > 7'd32);

    // Next-state and output logic. The outputs depend only on the registered
    // state, apart from the accept pulse in IDLE, which follows req_valid
    // within the same cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        data_d   = data_q;
        len_d    = len_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        req_ready               = '0;
        resp_valid              = '0;
        resp_data               = '0;
        resp_err                = 1'b0;
        core_input_val          = '0;
        core_input_length_bytes = '0;
        core_start_eval         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    // Qualify with rst_n so the accept pulse is also silent
                    // while reset is held.
                    req_ready = (NUM_REQ'(1) << pick_idx) & {NUM_REQ{rst_n}};
                    gnt_d     = pick_idx;
                    rr_ptr_d  = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    cnt_d     = '0;
                    if (pick_len_bad) begin
                        data_d   = '0;
                        len_d    = '0;
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        data_d   = pick_data;
                        len_d    = pick_len;
                        err_d    = 1'b0;
                        state_d  = ST_START;
                    end
                end
            end

            ST_START: begin
                // A ready left high by the previous job is ignored here.
                core_start_eval         = 1'b1;
                core_input_val          = data_q;
                core_input_length_bytes = len_q;
                if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            ST_WAIT: begin
                core_input_val          = data_q;
                core_input_length_bytes = len_q;
                if (core_eval_output_ready) begin
                    result_d = core_output_val;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                resp_valid = NUM_REQ'(1) << gnt_q;
                resp_data  = result_q;
                resp_err   = err_q;
                if (resp_ready[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            data_q   <= '0;
            len_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            data_q   <= data_d;
            len_q    <= len_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_eaglesong_digest_arbiter.sv
// Testbench for eaglesong_digest_arbiter.
//
// Stands in a small behavioural core model for the real digest core. The
// model returns the known Eaglesong digest for "Hello, world!\n" and a
// simple reversible scramble of the message for every other input.
// Expected responses come from that same model function. The inputs are
// driven 1 ns after the rising edge, and the outputs are sampled on the
// falling edge.

module tb_eaglesong_digest_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 120;
    localparam int MODEL_LAT    = 3;
    localparam int NORMAL_WAIT  = MODEL_LAT + 1;

    localparam logic [255:0] HELLO_MSG    = 256'h0A21646C726F77202C6F6C6C6548;
    localparam logic [255:0] HELLO_DIGEST =
        256'hD6727D073CE7EC1ECA9F52DBD0E4954B3F4DCB6B0B43C25D6162D141247E8664;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*256-1:0] req_data;
    logic [NUM_REQ*7-1:0]   req_len;
    logic [NUM_REQ-1:0]     resp_valid;
    logic [NUM_REQ-1:0]     resp_ready;
    logic [255:0]           resp_data;
    logic                   resp_err;
    logic [255:0]           core_input_val;
    logic [6:0]             core_input_length_bytes;
    logic                   core_start_eval;
    logic [255:0]           core_output_val        = '0;
    logic                   core_eval_output_ready = 1'b0;

    int   compareCount  = 0;
    int   mismatchCount = 0;
    int   illegalReady  = 0;
    bit   busy          = 1'b0;
    bit   neverReady    = 1'b0;
    int   modelCnt      = 0;
    logic [255:0] modelMsg = '0;
    logic [6:0]   modelLen = '0;

    eaglesong_digest_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_data                (req_data),
        .req_len                 (req_len),
        .resp_valid              (resp_valid),
        .resp_ready              (resp_ready),
        .resp_data               (resp_data),
        .resp_err                (resp_err),
        .core_input_val          (core_input_val),
        .core_input_length_bytes (core_input_length_bytes),
        .core_start_eval         (core_start_eval),
        .core_output_val         (core_output_val),
        .core_eval_output_ready  (core_eval_output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] fakeDigest(input logic [255:0] msg, input logic [6:0] len);
        if (msg == HELLO_MSG && len == 7'd14) begin
            return HELLO_DIGEST;
        end
        return ~{msg[127:0], msg[255:128]} ^ {249'd0, len};
    endfunction

    // Core model: start clears ready and captures the input; MODEL_LAT cycles
    // after start drops, ready rises and stays high until the next start.
    always @(posedge clk) begin
        if (core_start_eval) begin
            modelCnt               <= MODEL_LAT;
            core_eval_output_ready <= 1'b0;
            modelMsg               <= core_input_val;
            modelLen               <= core_input_length_bytes;
        end else if (modelCnt != 0) begin
            modelCnt <= modelCnt - 1;
            if (modelCnt == 1 && !neverReady) begin
                core_eval_output_ready <= 1'b1;
                core_output_val        <= fakeDigest(modelMsg, modelLen);
            end
        end
    end

    // Any accept pulse while a job is outstanding, or a non-one-hot pulse,
    // is illegal.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            if (req_ready != '0) begin
                if (busy || $countones(req_ready) != 1) begin
                    illegalReady <= illegalReady + 1;
                end
                if ((req_ready & req_valid) != '0) begin
                    busy <= 1'b1;
                end
            end
            if ((resp_valid & resp_ready) != '0) begin
                busy <= 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic [255:0] msg, input logic [6:0] len);
        req_valid[idx]            = 1'b1;
        req_data[idx*256 +: 256]  = msg;
        req_len[idx*7 +: 7]       = len;
    endtask

    // Waits for the grant and checks that it went to idx. After the accept
    // edge it withdraws the job and corrupts the slot, so a design that
    // re-reads the request shows up.
    task automatic waitAccept(input string tag, input int idx, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (req_ready != '0) found = 1'b1;
            else waited++;
        end
        checkOutput({tag, "/grant"}, 256'(req_ready), 256'd1 << idx);
        tick();
        req_valid[idx]           = 1'b0;
        req_data[idx*256 +: 256] = '1;
        req_len[idx*7 +: 7]      = 7'h7F;
    endtask

    task automatic collectResp(input string tag, input int idx, input logic [255:0] msg,
                               input logic [6:0] len, input logic expErr,
                               input int expStart, input int expWait);
        int   startCnt;
        int   waitCnt;
        int   inputBad;
        bit   seen;
        logic [255:0] expData;
        startCnt = 0;
        waitCnt  = 0;
        inputBad = 0;
        seen     = 1'b0;
        expData  = expErr ? 256'd0 : fakeDigest(msg, len);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                seen = 1'b1;
            end else begin
                if (core_start_eval) startCnt++;
                else waitCnt++;
                if (core_input_val !== msg || core_input_length_bytes !== len) inputBad++;
            end
        end
        checkOutput({tag, "/resp_valid"}, 256'(resp_valid), 256'd1 << idx);
        checkOutput({tag, "/resp_err"}, 256'(resp_err), 256'(expErr));
        checkOutput({tag, "/resp_data"}, resp_data, expData);
        checkOutput({tag, "/start cycles"}, 256'(startCnt), 256'(expStart));
        checkOutput({tag, "/wait cycles"}, 256'(waitCnt), 256'(expWait));
        checkOutput({tag, "/core input"}, 256'(inputBad), 256'd0);
    endtask

    task automatic ackResp(input string tag, input int idx);
        tick();
        resp_ready[idx] = 1'b1;
        tick();
        resp_ready[idx] = 1'b0;
        checkOutput({tag, "/released"}, 256'(resp_valid), 256'd0);
    endtask

    initial begin
        int waited;
        int unstable;
        logic [255:0] msgs [NUM_REQ];
        logic [6:0]   lens [NUM_REQ];

        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_len    = '0;
        resp_ready = '0;

        // Reset state
        @(negedge clk);
        checkOutput("reset/req_ready", 256'(req_ready), 256'd0);
        checkOutput("reset/resp_valid", 256'(resp_valid), 256'd0);
        checkOutput("reset/resp_data", resp_data, 256'd0);
        checkOutput("reset/resp_err", 256'(resp_err), 256'd0);
        checkOutput("reset/start", 256'(core_start_eval), 256'd0);
        checkOutput("reset/core_val", core_input_val, 256'd0);
        checkOutput("reset/core_len", 256'(core_input_length_bytes), 256'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single hello-world job
        applyStimulus(0, HELLO_MSG, 7'd14);
        waitAccept("t1", 0, waited);
        collectResp("t1", 0, HELLO_MSG, 7'd14, 1'b0, START_CYCLES, NORMAL_WAIT);
        ackResp("t1", 0);

        // Bad lengths: refused at accept, core never started
        applyStimulus(1, 256'h1234, 7'd0);
        waitAccept("t3len0", 1, waited);
        collectResp("t3len0", 1, 256'h1234, 7'd0, 1'b1, 0, 0);
        ackResp("t3len0", 1);
        applyStimulus(2, 256'h5678, 7'd33);
        waitAccept("t3len33", 2, waited);
        collectResp("t3len33", 2, 256'h5678, 7'd33, 1'b1, 0, 0);
        ackResp("t3len33", 2);

        // Core never answers: error after exactly TIMEOUT wait cycles
        neverReady = 1'b1;
        applyStimulus(3, 256'hDEADBEEF, 7'd4);
        waitAccept("t4", 3, waited);
        collectResp("t4", 3, 256'hDEADBEEF, 7'd4, 1'b1, START_CYCLES, TIMEOUT);
        ackResp("t4", 3);
        neverReady = 1'b0;

        // Pointer wrapped to 0; only req3 pending. The response is held for
        // 10 cycles while req0 waits and asserts its own resp_ready.
        applyStimulus(3, 256'hCAFE_F00D_0123, 7'd5);
        waitAccept("t5", 3, waited);
        collectResp("t5", 3, 256'hCAFE_F00D_0123, 7'd5, 1'b0, START_CYCLES, NORMAL_WAIT);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                applyStimulus(0, 256'h99887766554433, 7'd9);
                resp_ready[0] = 1'b1;
            end
            @(negedge clk);
            if (resp_valid !== 4'b1000 || resp_err !== 1'b0 ||
                resp_data !== fakeDigest(256'hCAFE_F00D_0123, 7'd5)) unstable++;
        end
        checkOutput("t5/hold stable", 256'(unstable), 256'd0);
        ackResp("t5", 3);
        resp_ready[0] = 1'b0;
        waitAccept("t5next", 0, waited);
        checkOutput("t5next/idle next cycle", 256'(waited), 256'd0);
        collectResp("t5next", 0, 256'h99887766554433, 7'd9, 1'b0, START_CYCLES, NORMAL_WAIT);
        ackResp("t5next", 0);

        // From reset, all four requesters at once: strict 0,1,2,3 order
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        msgs[0] = HELLO_MSG;
        lens[0] = 7'd14;
        msgs[1] = 256'h636261;
        lens[1] = 7'd3;
        msgs[2] = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        lens[2] = 7'd32;
        msgs[3] = 256'h41;
        lens[3] = 7'd1;
        for (int k = 0; k < NUM_REQ; k++) begin
            applyStimulus(k, msgs[k], lens[k]);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            waitAccept($sformatf("t2req%0d", k), k, waited);
            collectResp($sformatf("t2req%0d", k), k, msgs[k], lens[k], 1'b0, START_CYCLES, NORMAL_WAIT);
            ackResp($sformatf("t2req%0d", k), k);
        end

        // Asynchronous reset during WAIT, then a clean job
        neverReady = 1'b1;
        applyStimulus(2, 256'hABCDEF0011223344, 7'd20);
        waitAccept("t6", 2, waited);
        repeat (6) @(negedge clk);
        checkOutput("t6/in wait start", 256'(core_start_eval), 256'd0);
        checkOutput("t6/in wait core_val", core_input_val, 256'hABCDEF0011223344);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6/reset resp_valid", 256'(resp_valid), 256'd0);
        checkOutput("t6/reset req_ready", 256'(req_ready), 256'd0);
        checkOutput("t6/reset start", 256'(core_start_eval), 256'd0);
        checkOutput("t6/reset core_val", core_input_val, 256'd0);
        checkOutput("t6/reset core_len", 256'(core_input_length_bytes), 256'd0);
        checkOutput("t6/reset resp_err", 256'(resp_err), 256'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        neverReady = 1'b0;
        applyStimulus(0, HELLO_MSG, 7'd14);
        waitAccept("t6after", 0, waited);
        collectResp("t6after", 0, HELLO_MSG, 7'd14, 1'b0, START_CYCLES, NORMAL_WAIT);
        ackResp("t6after", 0);

        @(negedge clk);
        checkOutput("no req_ready outside idle", 256'(illegalReady), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
